lsu_bus_bridge: RTL and testbench

//  Load/store unit sitting directly downstream of the core datapath's memory port
//  (Mem_WrAddr / Mem_WrData / ReadData). Converts single-cycle core accesses into

---
 rtl/lsu_bus_bridge.sv | 96 +++++++++
 tb/tb_lsu_bus_bridge.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: turns single-cycle core loads/stores into valid/ready bus transactions,
// stalling the core until the response arrives and formatting load data for writeback.
module lsu_bus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemErr,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        we, err, access, legal, aligned, ok;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, rdata, st_data, lane;
  logic [3:0]  wstrb, st_strb;
  always_comb begin
    access  = MemRead | MemWrite;
    legal   = MemWrite ? (Funct3[2:1] == 2'b00 || Funct3 == 3'b010)
                       : (Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010 ||
                          Funct3 == 3'b100 || Funct3 == 3'b101);
    aligned = Funct3[1:0] == 2'b00 || (Funct3[1:0] == 2'b01 && !Mem_WrAddr[0]) ||
              (Funct3[1:0] == 2'b10 && Mem_WrAddr[1:0] == 2'b00);
    ok      = access & legal & aligned;
    st_data = Funct3[1:0] == 2'b00 ? {4{Mem_WrData[7:0]}} :
              Funct3[1:0] == 2'b01 ? {2{Mem_WrData[15:0]}} : Mem_WrData;
    st_strb = !MemWrite ? 4'b0000 :
              Funct3[1:0] == 2'b00 ? 4'b0001 << Mem_WrAddr[1:0] :
              Funct3[1:0] == 2'b01 ? (Mem_WrAddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    lane    = rdata >> {addr[1:0], 3'b000};
  end
  assign Stall         = (state == IDLE && ok) || state == REQ || state == WAIT;
  assign MemErr        = (state == IDLE && access && !ok) || (state == DONE && err);
  assign bus_req_valid = state == REQ;
  assign bus_we        = we;
  assign bus_addr      = {addr[31:2], 2'b00};
  assign bus_wdata     = wdata;
  assign bus_wstrb     = wstrb;
  assign ReadData = (state != DONE || we || err) ? 32'd0 :
                    f3 == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                    f3 == 3'b100 ? {24'd0, lane[7:0]} :
                    f3 == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
                    f3 == 3'b101 ? {16'd0, lane[15:0]} : lane;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      we    <= 1'b0;
      err   <= 1'b0;
      f3    <= '0;
      addr  <= '0;
      wdata <= '0;
      wstrb <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (ok) begin
          state <= REQ;
          we    <= MemWrite;
          err   <= 1'b0;
          f3    <= Funct3;
          addr  <= Mem_WrAddr;
          wdata <= st_data;
          wstrb <= st_strb;
        end
        REQ: if (bus_req_ready) begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: if (bus_rsp_valid) begin
          state <= DONE;
          rdata <= bus_rdata;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state <= DONE;
          err   <= 1'b1;
        end else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: directed table vectors, multi-cycle corner sequences and random
// accesses checked against a byte-level reference model of the bridge.
module tb_lsu_bus_bridge;
  localparam int TO = 255;
  logic        clk = 0, reset = 0, MemRead = 0, MemWrite = 0;
  logic [2:0]  Funct3 = 0;
  logic [31:0] Mem_WrAddr = 0, Mem_WrData = 0, bus_rdata = 0;
  logic        bus_req_ready = 0, bus_rsp_valid = 0;
  logic [31:0] ReadData, bus_addr, bus_wdata;
  logic        Stall, MemErr, bus_req_valid, bus_we;
  logic [3:0]  bus_wstrb;
  int pass = 0, total = 0;

  lsu_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData), .ReadData(ReadData), .Stall(Stall),
    .MemErr(MemErr), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Reference model: access size in bytes, byte-lane arithmetic, no state machine
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a, d, rw,
                       output logic ok, output logic [3:0] strb, output logic [31:0] wd, rv);
    int sz;
    logic [63:0] v, mask;
    logic legal;
    sz    = 1 << f3[1:0];
    legal = wr ? (f3 < 3) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    ok    = legal && (a % sz == 0);
    strb  = wr ? 4'(((1 << sz) - 1) << (a % 4)) : 4'd0;
    for (int k = 0; k < 4; k++) wd[8*k +: 8] = d[8*(k % sz) +: 8];
    v    = 64'(rw) >> (8 * (a % 4));
    mask = (64'd1 << (8 * sz)) - 1;
    v    = v & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    rv = v[31:0];
  endtask

  // Drives one core access; rl = cycles ready stays low, sl = WAIT cycles before rsp (-1 = none)
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a, d, rw,
                        input int rl, sl, input logic ok, input logic [3:0] strb,
                        input logic [31:0] wd, rv);
    int nw;
    MemRead = !wr; MemWrite = wr; Funct3 = f3; Mem_WrAddr = a; Mem_WrData = d;
    @(negedge clk);
    chk("idle_stall", Stall, ok);
    chk("idle_err", MemErr, !ok);
    chk("idle_valid", bus_req_valid, 0);
    chk("idle_rdata", ReadData, 0);
    @(posedge clk); #1;
    if (!ok) begin
      MemRead = 0; MemWrite = 0;
      @(negedge clk);
      chk("err_no_req", bus_req_valid, 0);
      chk("err_no_stall", Stall, 0);
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i <= rl; i++) begin
      bus_req_ready = (i == rl);
      @(negedge clk);
      chk("req_valid", bus_req_valid, 1);
      chk("req_stall", Stall, 1);
      chk("req_we", bus_we, wr);
      chk("req_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("req_strb", bus_wstrb, strb);
      if (wr) chk("req_wdata", bus_wdata, wd);
      @(posedge clk); #1;
    end
    bus_req_ready = 0;
    nw = sl < 0 ? TO : sl + 1;
    for (int i = 0; i < nw; i++) begin
      bus_rsp_valid = (i == sl);
      bus_rdata = (i == sl) ? rw : 32'h5A5A_5A5A;
      @(negedge clk);
      chk("wait_stall", Stall, 1);
      chk("wait_valid", bus_req_valid, 0);
      @(posedge clk); #1;
    end
    bus_rsp_valid = 0;
    @(negedge clk);
    chk("done_stall", Stall, 0);
    chk("done_err", MemErr, sl < 0);
    chk("done_rdata", ReadData, (wr || sl < 0) ? 32'd0 : rv);
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0;
    @(negedge clk);
    chk("after_stall", Stall, 0);
    chk("after_rdata", ReadData, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic wr; logic [2:0] f3; logic [31:0] a, d, rw; int rl, sl;
    logic ok; logic [3:0] strb; logic [31:0] wd, rv;
  } vec_t;

  initial begin
    vec_t tbl[14];
    logic ok, wr;
    logic [2:0] f3;
    logic [3:0] strb;
    logic [31:0] wd, rv, a, d, rw;
    tbl[0]  = '{1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 4'b1111, 32'hDEADBEEF, 0};
    tbl[1]  = '{0, 3'b000, 32'h203, 0, 32'h80112233, 0, 0, 1, 4'b0000, 0, 32'hFFFFFF80};
    tbl[2]  = '{0, 3'b100, 32'h203, 0, 32'h80112233, 0, 0, 1, 4'b0000, 0, 32'h00000080};
    tbl[3]  = '{1, 3'b001, 32'h1001, 32'h1234, 0, 0, 0, 0, 4'b0000, 0, 0};
    tbl[4]  = '{1, 3'b000, 32'h12, 32'hAB, 0, 3, 0, 1, 4'b0100, 32'hABABABAB, 0};
    tbl[5]  = '{0, 3'b001, 32'h202, 0, 32'h80112233, 1, 1, 1, 4'b0000, 0, 32'hFFFF8011};
    tbl[6]  = '{0, 3'b101, 32'h202, 0, 32'h80112233, 0, 2, 1, 4'b0000, 0, 32'h00008011};
    tbl[7]  = '{0, 3'b010, 32'h300, 0, 32'h12345678, 0, 2, 1, 4'b0000, 0, 32'h12345678};
    tbl[8]  = '{1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0, 1, 4'b1100, 32'hABCDABCD, 0};
    tbl[9]  = '{0, 3'b010, 32'h302, 0, 0, 0, 0, 0, 4'b0000, 0, 0};
    tbl[10] = '{0, 3'b011, 32'h300, 0, 0, 0, 0, 0, 4'b0000, 0, 0};
    tbl[11] = '{1, 3'b100, 32'h300, 0, 0, 0, 0, 0, 4'b0000, 0, 0};
    tbl[12] = '{0, 3'b000, 32'h201, 0, 32'h11228344, 0, 0, 1, 4'b0000, 0, 32'hFFFFFF83};
    tbl[13] = '{0, 3'b010, 32'h400, 0, 32'hCAFEF00D, 0, -1, 1, 4'b0000, 0, 0};
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_stall", Stall, 0);
    chk("rst_err", MemErr, 0);
    chk("rst_valid", bus_req_valid, 0);
    chk("rst_rdata", ReadData, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_strb", bus_wstrb, 0);
    @(posedge clk); #1;
    foreach (tbl[i])
      access(tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].d, tbl[i].rw, tbl[i].rl, tbl[i].sl,
             tbl[i].ok, tbl[i].strb, tbl[i].wd, tbl[i].rv);
    // reset while waiting for a response; the late response must be dropped
    MemRead = 1; Funct3 = 3'b010; Mem_WrAddr = 32'h500;
    bus_req_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_req_ready = 0;
    @(negedge clk);
    chk("mid_wait_stall", Stall, 1);
    reset = 0; MemRead = 0;
    @(posedge clk); #1;
    reset = 1; bus_rsp_valid = 1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mid_rst_stall", Stall, 0);
    chk("mid_rst_valid", bus_req_valid, 0);
    @(posedge clk); #1;
    bus_rsp_valid = 0;
    @(negedge clk);
    chk("late_rsp_rdata", ReadData, 0);
    chk("late_rsp_err", MemErr, 0);
    chk("late_rsp_stall", Stall, 0);
    @(posedge clk); #1;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom & 32'h0000_0FFF;
      d  = $urandom;
      rw = $urandom;
      model(wr, f3, a, d, rw, ok, strb, wd, rv);
      access(wr, f3, a, d, rw, $urandom_range(0, 3), $urandom_range(0, 3), ok, strb, wd, rv);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
